// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and fetch-stage FSM encoding.
package cpu_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned InstWidth = 32;

    function automatic int unsigned pc_step(input int unsigned inst_width);
        return inst_width / 8;
    endfunction

    localparam int unsigned PcStep = pc_step(InstWidth);

    typedef enum logic [1:0] {
        FETCH_BOOT,
        FETCH_RUN,
        FETCH_FLUSH
    } FetchState_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO between the ICache response path and decode; flush wins over push.
module fetch_buf #(
    parameter int unsigned DATA  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DATA-1:0]          wdata_i,
    output logic [DATA-1:0]          rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues in-order ICache requests under a credit
// limit, buffers responses for decode and discards wrong-path work on redirects.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR      = AddrWidth,
    parameter int unsigned     INST      = InstWidth,
    parameter logic [ADDR-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_,
    output logic            fetch_e_,
    output logic [ADDR-1:0] fetch_pc,
    input  logic            ic_e_,
    input  logic [ADDR-1:0] ic_pc,
    input  logic [INST-1:0] ic_inst,
    output logic            inst_e_,
    output logic [ADDR-1:0] inst_pc,
    output logic [INST-1:0] inst,
    input  logic            dec_stall,
    input  logic            dec_jump_,
    input  logic            dec_branch_,
    input  logic [ADDR-1:0] dec_target
);

    localparam int unsigned     CW    = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned     DW    = ADDR + INST;
    localparam logic [ADDR-1:0] PcInc = ADDR'(pc_step(INST));

    FetchState_t     state_q, state_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   stale_q, stale_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic [DW-1:0]   fifo_rdata;

    logic            redirect, resp, resp_stale, issue, push, pop, inst_vld;
    logic [CW:0]     budget;

    always_comb begin
        redirect   = (!dec_jump_ || !dec_branch_) && (state_q != FETCH_BOOT);
        resp       = !ic_e_;
        resp_stale = resp && (stale_q != '0);
        // Every unanswered request, live or stale, reserves a FIFO slot.
        budget     = {1'b0, stale_q} + {1'b0, outstanding_q} + {1'b0, fifo_count};
        issue      = (state_q == FETCH_RUN) && !redirect && (budget < (CW + 1)'(BUF_DEPTH));
        push       = resp && !resp_stale && !redirect;
        inst_vld   = !fifo_empty && (state_q != FETCH_FLUSH);
        pop        = inst_vld && !dec_stall && !redirect;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        stale_d       = stale_q;

        unique case (state_q)
            FETCH_BOOT:  state_d = FETCH_RUN;
            FETCH_RUN:   if (redirect) state_d = FETCH_FLUSH;
            FETCH_FLUSH: state_d = redirect ? FETCH_FLUSH : FETCH_RUN;
            default:     state_d = FETCH_BOOT;
        endcase

        if (redirect) begin
            pc_d          = dec_target;
            outstanding_d = '0;
            // Any response this cycle retires one request, whichever path it was on.
            stale_d       = stale_q + outstanding_q - CW'(resp);
        end else begin
            if (issue) pc_d = pc_q + PcInc;
            outstanding_d = outstanding_q + CW'(issue) - CW'(push);
            stale_d       = stale_q - CW'(resp_stale);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q       <= FETCH_BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    fetch_buf #(
        .DATA  (DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset_  (reset_),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({ic_pc, ic_inst}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fetch_e_ = !issue;
    assign fetch_pc = pc_q;
    assign inst_e_  = !inst_vld;
    assign {inst_pc, inst} = inst_vld ? fifo_rdata : '0;

    no_push_when_full: assert property (@(posedge clk) disable iff (!reset_)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomised and directed bench for fetch_ctrl against a request-list reference model.
module tb_fetch_ctrl;

    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        fetch_e_;
    logic [31:0] fetch_pc;
    logic        ic_e_ = 1'b1;
    logic [31:0] ic_pc = '0;
    logic [31:0] ic_inst = '0;
    logic        inst_e_;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        dec_stall = 1'b0;
    logic        dec_jump_ = 1'b1;
    logic        dec_branch_ = 1'b1;
    logic [31:0] dec_target = '0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .reset_      (reset_),
        .fetch_e_    (fetch_e_),
        .fetch_pc    (fetch_pc),
        .ic_e_       (ic_e_),
        .ic_pc       (ic_pc),
        .ic_inst     (ic_inst),
        .inst_e_     (inst_e_),
        .inst_pc     (inst_pc),
        .inst        (inst),
        .dec_stall   (dec_stall),
        .dec_jump_   (dec_jump_),
        .dec_branch_ (dec_branch_),
        .dec_target  (dec_target)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct packed { logic [31:0] pc; logic live; } req_t;
    typedef struct packed { logic [31:0] pc; int due; } icq_t;

    ent_t        m_fifo[$];
    req_t        m_req[$];
    icq_t        icq[$];
    logic [31:0] flog[$];
    logic [31:0] dlog[$];
    logic [31:0] m_pc;
    bit          m_boot, m_flush, armed;
    bit          e_issue, e_pop, e_redir, s_fetch;
    logic [31:0] s_fetch_pc;
    int          cyc, last_due, lat, rel_cyc, first_vld;
    int          vectors, miscompares;

    function automatic logic [31:0] icache_word(input logic [31:0] pc);
        return (pc * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] flog_at(input int i);
        return (i < flog.size()) ? flog[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] dlog_at(input int i);
        return (i < dlog.size()) ? dlog[i] : 32'hxxxx_xxxx;
    endfunction

    // Compare against the model, then advance the model over the coming clock edge.
    always @(negedge clk) begin
        bit   redir, vld;
        req_t r;
        int   due;
        if (armed) begin
            redir   = (!dec_jump_ || !dec_branch_) && !m_boot;
            vld     = (m_fifo.size() > 0) && !m_flush;
            e_redir = redir;
            e_issue = !m_boot && !m_flush && !redir && (m_req.size() + m_fifo.size() < Depth);
            e_pop   = vld && !dec_stall && !redir;
            chk("fetch_e_", 32'(fetch_e_), 32'(!e_issue));
            chk("fetch_pc", fetch_pc, m_pc);
            chk("inst_e_", 32'(inst_e_), 32'(!vld));
            if (vld) begin
                chk("inst_pc", inst_pc, m_fifo[0].pc);
                chk("inst", inst, m_fifo[0].inst);
            end
            if (fetch_e_ === 1'b0) flog.push_back(fetch_pc);
            if (inst_e_ === 1'b0 && !dec_stall && !redir) dlog.push_back(inst_pc);
            if (inst_e_ === 1'b0 && first_vld < 0) first_vld = rel_cyc;
            s_fetch    = (fetch_e_ === 1'b0);
            s_fetch_pc = fetch_pc;
        end
        if (reset_ === 1'b0) begin
            m_fifo.delete(); m_req.delete(); icq.delete();
            m_pc = '0; m_boot = 1; m_flush = 0; last_due = 0;
            rel_cyc = 0; first_vld = -1; armed = 1;
        end else if (armed) begin
            if (ic_e_ === 1'b0) begin
                if (m_req.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    r = m_req.pop_front();
                    if (r.live && !e_redir) m_fifo.push_back('{pc: r.pc, inst: icache_word(r.pc)});
                end
            end
            if (e_redir) begin
                foreach (m_req[i]) m_req[i].live = 1'b0;
                m_fifo.delete();
                m_pc = dec_target;
                m_flush = 1;
            end else begin
                if (e_pop) void'(m_fifo.pop_front());
                if (e_issue) begin
                    m_req.push_back('{pc: m_pc, live: 1'b1});
                    m_pc = m_pc + 32'd4;
                end
                m_flush = 0;
            end
            m_boot = 0;
            if (s_fetch) begin
                due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                icq.push_back('{pc: s_fetch_pc, due: due});
                last_due = due;
            end
            rel_cyc++;
        end
        cyc++;
    end

    task automatic step(input bit rn, input bit st, input bit jn, input bit bn,
                        input logic [31:0] tg);
        icq_t q;
        @(posedge clk);
        #1;
        reset_ = rn; dec_stall = st; dec_jump_ = jn; dec_branch_ = bn; dec_target = tg;
        if (icq.size() > 0 && icq[0].due <= cyc) begin
            q = icq.pop_front();
            ic_e_ = 1'b0; ic_pc = q.pc; ic_inst = icache_word(q.pc);
        end else begin
            ic_e_ = 1'b1; ic_pc = '0; ic_inst = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b1, 1'b1, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fetch_e_"}, 32'(fetch_e_), 32'd1);
        chk({tag, "_inst_e_"}, 32'(inst_e_), 32'd1);
        chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
    endtask

    task automatic do_reset(input int l);
        lat = l;
        step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        @(negedge clk);
        check_reset_outputs("reset");
        #1;
        flog.delete();
        dlog.delete();
    endtask

    initial begin
        int n, bad;
        bit st, jn, bn;
        int r;
        logic [31:0] tg;
        vectors = 0; miscompares = 0; cyc = 0; lat = 1; armed = 0;

        // Streaming at latency 1.
        do_reset(1);
        idle(12);
        chk("p1_first_inst_cycle", first_vld, 3);
        chk("p1_fetch0", flog_at(0), 32'h0);
        chk("p1_fetch1", flog_at(1), 32'h4);
        chk("p1_fetch2", flog_at(2), 32'h8);
        chk("p1_deliver0", dlog_at(0), 32'h0);
        chk("p1_deliver1", dlog_at(1), 32'h4);
        chk("p1_deliver2", dlog_at(2), 32'h8);

        // Decode stalled: credits cap issue at the buffer depth.
        do_reset(1);
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b1, '0);
        chk("p2_issued_while_stalled", flog.size(), 4);
        chk("p2_delivered_while_stalled", dlog.size(), 0);
        idle(10);
        for (int i = 0; i < 5; i++) chk("p2_deliver_order", dlog_at(i), 32'(4 * i));

        // Jump with three requests in flight at latency 3.
        do_reset(3);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        idle(15);
        chk("p3_first_after_jump", dlog_at(0), 32'h100);
        bad = 0;
        foreach (dlog[i]) if (dlog[i] < 32'h100) bad++;
        chk("p3_no_old_pc", bad, 0);

        // Branch coinciding with a response.
        do_reset(1);
        idle(6);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
        n = dlog.size();
        idle(10);
        chk("p4_first_after_branch", dlog_at(n), 32'h40);
        chk("p4_second_after_branch", dlog_at(n + 1), 32'h44);

        // Back-to-back redirects: only the newer target survives.
        do_reset(2);
        idle(6);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        n = dlog.size();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h300);
        idle(12);
        chk("p5_first_after_double", dlog_at(n), 32'h300);
        bad = 0;
        foreach (dlog[i]) if (i >= n && dlog[i][31:8] == 24'h2) bad++;
        chk("p5_no_0x2xx", bad, 0);

        // PC wrap, then reset in the middle of traffic.
        do_reset(1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        n = flog.size();
        idle(6);
        chk("p6_wrap_pc0", flog_at(n), 32'hFFFF_FFFC);
        chk("p6_wrap_pc1", flog_at(n + 1), 32'h0000_0000);
        step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, 1'b1, '0);
        @(negedge clk);
        check_reset_outputs("midreset");
        idle(8);

        // Random traffic across latencies.
        for (int seg = 0; seg < 30; seg++) begin
            do_reset(int'($urandom_range(1, 4)));
            idle(1);
            for (int c = 0; c < 80; c++) begin
                st = ($urandom_range(0, 9) < 3);
                r  = int'($urandom_range(0, 99));
                jn = !(r < 4 || r == 7);
                bn = !((r >= 4 && r < 7) || r == 7);
                tg = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 9) == 0) tg = 32'hFFFF_FFF0;
                step(1'b1, st, jn, bn, tg);
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
